adsb_report_arbiter: RTL and testbench

- Merges report packets from up to NUM_SOURCES independent ADS-B demodulator channels onto the single report AXI-stream on the AXI clock domain.
- Arbitration is round-robin and packet-atomic: once a source is granted, its whole packet (through `last`) goes out before any other source is considered.
- Sits between the per-channel report FIFOs and the M_axis report port. It also keeps a running count of forwarded packets.

---
 rtl/adsb_report_arbiter.sv | 165 ++++++++++++++++
 tb/tb_adsb_report_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adsb_report_arbiter.sv
// adsb_report_arbiter
// Round-robin, packet-atomic merge of NUM_SOURCES report streams onto one
// AXI-stream master on the Axi_clk domain. Once a source is granted, its whole
// packet (through last) is forwarded before any other source is considered.
// Forwarded packets are counted in Packet_count, which wraps modulo 2^32.
//
// Ports:
//   Axi_clk, Axi_resetn        clock (rising edge), asynchronous active-low reset
//   Source_enable[N]           per-source enable, sampled only while idle
//   S_axis_valid/last[N]       per-source stream inputs
//   S_axis_data[N*W]           source k occupies bits [k*W +: W]
//   S_axis_ready[N]            ready, asserted only toward the granted source
//   M_axis_valid/data/last     registered output stream (1 cycle latency)
//   M_axis_ready               downstream ready
//   Packet_count[32]           packets completed on M_axis
//   Active_source              index of the currently granted source
//
// Optional build macro ADSB_REPORT_ARB_SEQ_STAMP_EN: the beat at
// SEQ_WORD_INDEX of every packet is replaced by a global 32-bit sequence
// number, which advances on every completed packet.
module adsb_report_arbiter #(
  parameter int unsigned NUM_SOURCES    = 4,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned SEQ_WORD_INDEX = 1
) (
  input  logic                                  Axi_clk,
  input  logic                                  Axi_resetn,
  input  logic [NUM_SOURCES-1:0]                Source_enable,
  input  logic [NUM_SOURCES-1:0]                S_axis_valid,
  input  logic [NUM_SOURCES*AXI_DATA_WIDTH-1:0] S_axis_data,
  input  logic [NUM_SOURCES-1:0]                S_axis_last,
  output logic [NUM_SOURCES-1:0]                S_axis_ready,
  input  logic                                  M_axis_ready,
  output logic                                  M_axis_valid,
  output logic [AXI_DATA_WIDTH-1:0]             M_axis_data,
  output logic                                  M_axis_last,
  output logic [31:0]                           Packet_count,
  output logic [$clog2(NUM_SOURCES)-1:0]        Active_source
);

  localparam int unsigned SW = $clog2(NUM_SOURCES);

  typedef enum logic {S_IDLE, S_XFER} state_t;

  state_t                    state, state_nxt;
  logic [SW-1:0]             last_grant;
  logic [SW-1:0]             grant_idx;
  logic                      grant_found;
  logic [NUM_SOURCES-1:0]    req;
  logic                      take_ok;
  logic                      in_fire;
  logic                      out_fire;
  logic                      out_last_fire;
  logic [AXI_DATA_WIDTH-1:0] in_data;
  logic [AXI_DATA_WIDTH-1:0] out_data_nxt;

  assign req = S_axis_valid & Source_enable;

  // Cyclic priority search starting just after the previous winner.
  always_comb begin : grant_search
    logic [SW-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int unsigned i = 1; i <= NUM_SOURCES; i++) begin
      cand = SW'((32'(last_grant) + i) % NUM_SOURCES);
      if (!grant_found && req[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin : data_mux
    in_data = '0;
    for (int unsigned k = 0; k < NUM_SOURCES; k++) begin
      if (SW'(k) == Active_source) begin
        in_data = S_axis_data[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
      end
    end
  end

  // Once the last beat sits in the output register, stop accepting until it
  // drains so the next packet of the same source cannot slip in unarbitrated.
  assign take_ok       = !M_axis_valid || (M_axis_ready && !M_axis_last);
  assign in_fire       = (state == S_XFER) && S_axis_valid[Active_source] && take_ok;
  assign out_fire      = M_axis_valid && M_axis_ready;
  assign out_last_fire = out_fire && M_axis_last;

  always_comb begin : ready_gen
    S_axis_ready = '0;
    if (state == S_XFER) begin
      S_axis_ready[Active_source] = take_ok;
    end
  end

`ifdef ADSB_REPORT_ARB_SEQ_STAMP_EN
  logic [31:0] global_seq;
  logic [3:0]  beat_cnt;

  // beat_cnt is the index of the beat about to be registered to the output.
  always_ff @(posedge Axi_clk or negedge Axi_resetn) begin
    if (!Axi_resetn) begin
      global_seq <= '0;
      beat_cnt   <= '0;
    end else begin
      if (out_last_fire) begin
        global_seq <= global_seq + 32'd1;
        beat_cnt   <= '0;
      end else if (in_fire && beat_cnt != 4'd15) begin
        beat_cnt <= beat_cnt + 4'd1;
      end
    end
  end

  assign out_data_nxt = (32'(beat_cnt) == SEQ_WORD_INDEX) ?
                        AXI_DATA_WIDTH'(global_seq) : in_data;
`else
  assign out_data_nxt = in_data;
`endif

  always_ff @(posedge Axi_clk or negedge Axi_resetn) begin
    if (!Axi_resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin : fsm_next
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_found)   state_nxt = S_XFER;
      S_XFER:  if (out_last_fire) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Axi_clk or negedge Axi_resetn) begin
    if (!Axi_resetn) begin
      last_grant    <= SW'(NUM_SOURCES - 1);
      Active_source <= '0;
      M_axis_valid  <= 1'b0;
      M_axis_data   <= '0;
      M_axis_last   <= 1'b0;
      Packet_count  <= '0;
    end else begin
      if (state == S_IDLE && grant_found) begin
        Active_source <= grant_idx;
      end
      if (in_fire) begin
        M_axis_valid <= 1'b1;
        M_axis_data  <= out_data_nxt;
        M_axis_last  <= S_axis_last[Active_source];
      end else if (out_fire) begin
        M_axis_valid <= 1'b0;
      end
      if (out_last_fire) begin
        Packet_count <= Packet_count + 32'd1;
        last_grant   <= Active_source;
      end
    end
  end

endmodule

// File: tb/tb_adsb_report_arbiter.sv
module tb_adsb_report_arbiter;

  localparam int NS = 4;
  localparam int W  = 32;

  logic            Axi_clk = 1'b0;
  logic            Axi_resetn = 1'b0;
  logic [NS-1:0]   Source_enable;
  logic [NS-1:0]   S_axis_valid;
  logic [NS*W-1:0] S_axis_data;
  logic [NS-1:0]   S_axis_last;
  logic [NS-1:0]   S_axis_ready;
  logic            M_axis_ready;
  logic            M_axis_valid;
  logic [W-1:0]    M_axis_data;
  logic            M_axis_last;
  logic [31:0]     Packet_count;
  logic [1:0]      Active_source;

  adsb_report_arbiter #(
    .NUM_SOURCES(NS),
    .AXI_DATA_WIDTH(W),
    .SEQ_WORD_INDEX(1)
  ) dut (
    .Axi_clk(Axi_clk),
    .Axi_resetn(Axi_resetn),
    .Source_enable(Source_enable),
    .S_axis_valid(S_axis_valid),
    .S_axis_data(S_axis_data),
    .S_axis_last(S_axis_last),
    .S_axis_ready(S_axis_ready),
    .M_axis_ready(M_axis_ready),
    .M_axis_valid(M_axis_valid),
    .M_axis_data(M_axis_data),
    .M_axis_last(M_axis_last),
    .Packet_count(Packet_count),
    .Active_source(Active_source)
  );

  always #5 Axi_clk = ~Axi_clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rise0_cyc = 0;
  int first_cyc = 0;
  bit seen_first = 1'b0;
  int out_beats = 0;
  bit ready13_seen = 1'b0;
  bit bp_en = 1'b0;
  logic [31:0] tb_seq = '0;

  // Each entry is {last, data}.
  logic [32:0] src_q [NS][$];
  logic [32:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge Axi_clk);
    cyc++;
  end

  // Source drivers and downstream ready generator.
  initial begin
    logic [NS-1:0] fire;
    S_axis_valid = '0;
    S_axis_last  = '0;
    S_axis_data  = '0;
    M_axis_ready = 1'b1;
    fire = '0;
    forever begin
      @(negedge Axi_clk);
      fire = S_axis_valid & S_axis_ready;
      @(posedge Axi_clk);
      #1;
      for (int k = 0; k < NS; k++) begin
        if (fire[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        if (src_q[k].size() > 0) begin
          if (k == 0 && !S_axis_valid[0]) rise0_cyc = cyc;
          S_axis_valid[k]      = 1'b1;
          S_axis_last[k]       = src_q[k][0][32];
          S_axis_data[k*W +: W] = src_q[k][0][31:0];
        end else begin
          S_axis_valid[k] = 1'b0;
          S_axis_last[k]  = 1'b0;
        end
      end
      M_axis_ready = bp_en ? ($urandom_range(0, 99) < 80) : 1'b1;
    end
  end

  // Scoreboard monitor.
  initial begin
    logic [32:0] e;
    logic        stall;
    logic [W-1:0] held;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge Axi_clk);
      if (!Axi_resetn) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("hold_valid", {63'b0, M_axis_valid}, 64'd1);
          check("hold_data", {32'b0, M_axis_data}, {32'b0, held});
        end
        if (M_axis_valid && !seen_first) begin
          seen_first = 1'b1;
          first_cyc  = cyc;
        end
        if (M_axis_valid && M_axis_ready) begin
          out_beats++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %0h expected none", M_axis_data);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", {32'b0, M_axis_data}, {32'b0, e[31:0]});
            check("beat_last", {63'b0, M_axis_last}, {63'b0, e[32]});
          end
        end
        if (S_axis_ready[1] || S_axis_ready[3]) ready13_seen = 1'b1;
        stall = M_axis_valid && !M_axis_ready;
        held  = M_axis_data;
      end
    end
  end

  task automatic clear_all();
    for (int k = 0; k < NS; k++) src_q[k].delete();
    exp_q.delete();
    tb_seq = '0;
  endtask

  task automatic do_reset();
    Axi_resetn = 1'b0;
    clear_all();
    repeat (3) @(posedge Axi_clk);
    @(negedge Axi_clk);
    Axi_resetn = 1'b1;
  endtask

  task automatic send_pkt(input int src, input logic [31:0] base, input int len,
                          input bit w1_ones, input bit expect_it);
    logic [31:0] d;
    for (int i = 0; i < len; i++) begin
      d = base + 32'(i);
      if (w1_ones && i == 1) d = '1;
      src_q[src].push_back({(i == len - 1), d});
`ifdef ADSB_REPORT_ARB_SEQ_STAMP_EN
      if (i == 1) d = tb_seq;
`endif
      if (expect_it) exp_q.push_back({(i == len - 1), d});
    end
    if (expect_it) tb_seq = tb_seq + 32'd1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int c = 0; c < budget && exp_q.size() != 0; c++) @(negedge Axi_clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d beats outstanding expected 0", name, exp_q.size());
    end
    repeat (3) @(negedge Axi_clk);
  endtask

  initial begin
    Source_enable = '0;
    // Reset state
    repeat (2) @(negedge Axi_clk);
    check("rst_m_valid", {63'b0, M_axis_valid}, 64'd0);
    check("rst_m_last", {63'b0, M_axis_last}, 64'd0);
    check("rst_m_data", {32'b0, M_axis_data}, 64'd0);
    check("rst_s_ready", {60'b0, S_axis_ready}, 64'd0);
    check("rst_pkt_count", {32'b0, Packet_count}, 64'd0);
    check("rst_active", {62'b0, Active_source}, 64'd0);
    @(negedge Axi_clk);
    Axi_resetn = 1'b1;
    Source_enable = 4'hF;

    // Single source, 11-beat packet
    repeat (2) @(negedge Axi_clk);
    seen_first = 1'b0;
    send_pkt(0, 32'hAD5B0001, 11, 1'b0, 1'b1);
    wait_drain("single", 200);
    check("single_pkt_count", {32'b0, Packet_count}, 64'd1);
    check("single_latency", 64'(first_cyc - rise0_cyc), 64'd2);

    // Contention: all four sources hold 3-beat packets
    do_reset();
    for (int s = 0; s < NS; s++) send_pkt(s, 32'hC0000000 | (32'(s) << 16), 3, 1'b0, 1'b1);
    wait_drain("contention", 200);
    check("contention_pkt_count", {32'b0, Packet_count}, 64'd4);

    // Random backpressure, 100 packets in strict rotation
    do_reset();
    bp_en = 1'b1;
    for (int p = 0; p < 100; p++)
      send_pkt(p % NS, 32'hB0000000 | (32'(p) << 8), (p % 5) + 1, 1'b0, 1'b1);
    wait_drain("backpressure", 5000);
    bp_en = 1'b0;
    check("bp_pkt_count", {32'b0, Packet_count}, 64'd100);

    // Enable mask 0101: only sources 0 and 2 are served, alternating
    do_reset();
    Source_enable = 4'b0101;
    ready13_seen = 1'b0;
    for (int p = 0; p < 4; p++) begin
      send_pkt(0, 32'hE0000000 | (32'(p) << 8), 2, 1'b0, 1'b1);
      send_pkt(2, 32'hE2000000 | (32'(p) << 8), 3, 1'b0, 1'b1);
      send_pkt(1, 32'hE1000000 | (32'(p) << 8), 2, 1'b0, 1'b0);
      send_pkt(3, 32'hE3000000 | (32'(p) << 8), 2, 1'b0, 1'b0);
    end
    wait_drain("enable", 500);
    check("enable_pkt_count", {32'b0, Packet_count}, 64'd8);
    check("enable_ready13", {63'b0, ready13_seen}, 64'd0);
    check("enable_pending1", 64'(src_q[1].size()), 64'd8);

    // Asynchronous reset in the middle of a packet from source 1
    do_reset();
    Source_enable = 4'hF;
    send_pkt(0, 32'h60000000, 2, 1'b0, 1'b1);
    wait_drain("pre_reset", 100);
    out_beats = 0;
    send_pkt(1, 32'h61000000, 11, 1'b0, 1'b1);
    for (int c = 0; c < 100 && out_beats < 5; c++) @(posedge Axi_clk);
    check("mid_reached_beat5", {63'b0, (out_beats >= 5)}, 64'd1);
    @(negedge Axi_clk);
    #3;
    Axi_resetn = 1'b0;
    clear_all();
    #1;
    check("async_m_valid", {63'b0, M_axis_valid}, 64'd0);
    check("async_pkt_count", {32'b0, Packet_count}, 64'd0);
    check("async_active", {62'b0, Active_source}, 64'd0);
    check("async_s_ready", {60'b0, S_axis_ready}, 64'd0);
    repeat (2) @(posedge Axi_clk);
    @(negedge Axi_clk);
    Axi_resetn = 1'b1;
    // Source 0 must win first again even though source 1 had the last grant.
    send_pkt(0, 32'h70000000, 2, 1'b0, 1'b1);
    send_pkt(1, 32'h71000000, 2, 1'b0, 1'b1);
    wait_drain("post_reset", 100);
    check("post_reset_pkt_count", {32'b0, Packet_count}, 64'd2);

    // Sequence stamp on word 1
    do_reset();
    for (int p = 0; p < 3; p++) send_pkt(2, 32'h5E000000 | (32'(p) << 8), 3, 1'b1, 1'b1);
    wait_drain("seq", 100);
    check("seq_pkt_count", {32'b0, Packet_count}, 64'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
